wb_apb_bridge: RTL and testbench

Wishbone-classic slave to APB master bridge that sits directly upstream of the peripheral-extender APB slaves (GPIO block and siblings). It decodes a 64 KiB window on the Caravel user Wishbone bus and turns each single Wishbone access into one APB SETUP/ACCESS transfer. It returns read data and ack, or an error on a PREADY timeout. It runs one transfer at a time, with no pipelining and no posted writes.

---
 rtl/wb_apb_bridge_if.sv | 41 ++++
 rtl/wb_apb_bridge.sv | 139 +++++++++++++
 tb/tb_wb_apb_bridge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_apb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_apb_bridge_if
//  Brief    : Wishbone-classic slave side and APB master side signals of the
//             wb_apb_bridge, bundled with bridge (slave) and master modports.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_apb_bridge_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] apb_addr;
    logic        apb_sel;
    logic        apb_ena;
    logic        apb_write;
    logic [31:0] apb_wdata;
    logic [3:0]  apb_pstb;
    logic [31:0] apb_rdata;
    logic        apb_rready;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  apb_rdata, apb_rready,
        output wb_dat_o, wb_ack, wb_err,
        output apb_addr, apb_sel, apb_ena, apb_write, apb_wdata, apb_pstb
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output apb_rdata, apb_rready,
        input  wb_dat_o, wb_ack, wb_err,
        input  apb_addr, apb_sel, apb_ena, apb_write, apb_wdata, apb_pstb
    );
endinterface
`default_nettype wire

// File: rtl/wb_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : wb_apb_bridge
//  Brief    : Wishbone-classic slave to APB master bridge, one transfer at a
//             time, with PREADY timeout reported as a Wishbone error.
//  Revision : 1.0  initial release
// ============================================================================
module wb_apb_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic           clock,
    input  logic           rst,
    wb_apb_bridge_if.slave bus
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_SETUP    = 2'd1;
    localparam logic [1:0]  c_ACCESS   = 2'd2;
    localparam logic [1:0]  c_RESP     = 2'd3;
    localparam logic [7:0]  c_CNT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [15:0] c_BASE_HI  = BASE_ADDR[31:16];

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_cnt;
    logic        r_abort;
    logic [31:0] r_apb_addr;
    logic        r_apb_sel;
    logic        r_apb_ena;
    logic        r_apb_write;
    logic [31:0] r_apb_wdata;
    logic [3:0]  r_apb_pstb;
    logic        r_wb_ack;
    logic        r_wb_err;
    logic [31:0] r_wb_dat_o;

    logic w_req;
    logic w_accept;
    logic w_done_ok;
    logic w_timeout;
    logic w_live;

    always_comb begin
        w_req        = bus.wb_cyc & bus.wb_stb & (bus.wb_adr[31:16] == c_BASE_HI);
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = c_SETUP;
                end
            end
            c_SETUP: w_next_state = c_ACCESS;
            c_ACCESS: begin
                if (bus.apb_rready) begin
                    w_done_ok    = 1'b1;
                    w_next_state = c_RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = c_RESP;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A master that dropped cyc mid-transfer must not see a response later.
    assign w_live = bus.wb_cyc & ~r_abort;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_abort     <= 1'b0;
            r_apb_addr  <= 32'h0;
            r_apb_sel   <= 1'b0;
            r_apb_ena   <= 1'b0;
            r_apb_write <= 1'b0;
            r_apb_wdata <= 32'h0;
            r_apb_pstb  <= 4'h0;
            r_wb_ack    <= 1'b0;
            r_wb_err    <= 1'b0;
            r_wb_dat_o  <= 32'h0;
        end else begin
            r_wb_ack <= 1'b0;
            r_wb_err <= 1'b0;
            if (w_accept) begin
                r_apb_addr  <= {16'h0000, bus.wb_adr[15:0]};
                r_apb_write <= bus.wb_we;
                r_apb_wdata <= bus.wb_dat_i;
                r_apb_pstb  <= bus.wb_sel;
                r_apb_sel   <= 1'b1;
                r_apb_ena   <= 1'b0;
                r_abort     <= 1'b0;
            end
            if ((r_state == c_SETUP || r_state == c_ACCESS) && !bus.wb_cyc) begin
                r_abort <= 1'b1;
            end
            if (r_state == c_SETUP) begin
                r_apb_ena <= 1'b1;
                r_cnt     <= 8'd0;
            end
            if (r_state == c_ACCESS) begin
                if (w_done_ok || w_timeout) begin
                    r_apb_sel  <= 1'b0;
                    r_apb_ena  <= 1'b0;
                    r_wb_ack   <= w_done_ok & w_live;
                    r_wb_err   <= w_timeout & w_live;
                    r_wb_dat_o <= (w_done_ok && !r_apb_write) ? bus.apb_rdata : 32'h0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.apb_addr  = r_apb_addr;
    assign bus.apb_sel   = r_apb_sel;
    assign bus.apb_ena   = r_apb_ena;
    assign bus.apb_write = r_apb_write;
    assign bus.apb_wdata = r_apb_wdata;
    assign bus.apb_pstb  = r_apb_pstb;
    assign bus.wb_ack    = r_wb_ack;
    assign bus.wb_err    = r_wb_err;
    assign bus.wb_dat_o  = r_wb_dat_o;

endmodule
`default_nettype wire

// File: tb/tb_wb_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_apb_bridge
//  Brief    : Directed plus randomized transfers against a transaction-level
//             timing/data model of the wb_apb_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_apb_bridge;

    localparam int c_T = 16;

    logic clock;
    logic rst;
    int   total;
    int   bad;

    wb_apb_bridge_if bus ();

    wb_apb_bridge #(
        .BASE_ADDR   (32'h3000_0000),
        .TIMEOUT_CYC (c_T)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] vec();
        return {28'h0, bus.apb_sel, bus.apb_ena, bus.wb_ack, bus.wb_err};
    endfunction

    // Transfer model: SETUP after the request edge, then one ACCESS cycle per
    // wait state plus one, or an error once TIMEOUT_CYC ACCESS edges pass.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int waits,
                        input logic [31:0] rdata, input bit drop, input bit hold);
        bit   in_win;
        bit   ok;
        int   done_edge;
        logic [31:0] exp_v;
        bus.wb_cyc    = 1'b1;
        bus.wb_stb    = 1'b1;
        bus.wb_we     = we;
        bus.wb_adr    = adr;
        bus.wb_dat_i  = dat;
        bus.wb_sel    = sel;
        bus.apb_rdata = rdata;
        in_win = (adr[31:16] == 16'h3000);
        if (!in_win) begin
            for (int i = 0; i < 20; i++) begin
                step();
                chk({tag, "_oow"}, vec(), 32'h0);
            end
            bus.wb_cyc = 1'b0;
            bus.wb_stb = 1'b0;
            return;
        end
        ok        = (waits < c_T);
        done_edge = ok ? 2 + waits : 1 + c_T;
        for (int e = 0; e <= done_edge + 1; e++) begin
            step();
            if (e == 0) begin
                exp_v = 32'h8;
            end else if (e < done_edge) begin
                exp_v = 32'hC;
            end else if (e == done_edge) begin
                exp_v = {30'h0, ok & ~drop, ~ok & ~drop};
            end else begin
                exp_v = 32'h0;
            end
            chk({tag, "_phase"}, vec(), exp_v);
            if (e == 0 || e == done_edge - 1) begin
                chk({tag, "_addr"},  bus.apb_addr,  {16'h0, adr[15:0]});
                chk({tag, "_wdata"}, bus.apb_wdata, dat);
                chk({tag, "_write"}, {31'h0, bus.apb_write}, {31'h0, we});
                chk({tag, "_pstb"},  {28'h0, bus.apb_pstb},  {28'h0, sel});
            end
            if (e == done_edge && !drop) begin
                chk({tag, "_dat_o"}, bus.wb_dat_o, (ok && !we) ? rdata : 32'h0);
            end
            if (e == 0) begin
                bus.apb_rready = (waits == 0);
                if (drop) begin
                    bus.wb_cyc = 1'b0;
                    bus.wb_stb = 1'b0;
                end
            end else if (e < done_edge) begin
                bus.apb_rready = (e > waits);
            end else if (e == done_edge) begin
                bus.apb_rready = 1'b0;
                if (!hold) begin
                    bus.wb_cyc = 1'b0;
                    bus.wb_stb = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;
        int          w;
        total = 0;
        bad   = 0;
        rst            = 1'b1;
        bus.wb_cyc     = 1'b0;
        bus.wb_stb     = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_sel     = 4'h0;
        bus.wb_adr     = 32'h0;
        bus.wb_dat_i   = 32'h0;
        bus.apb_rdata  = 32'h0;
        bus.apb_rready = 1'b0;
        repeat (3) step();
        chk("rst_phase", vec(), 32'h0);
        chk("rst_addr",  bus.apb_addr, 32'h0);
        chk("rst_wdata", bus.apb_wdata, 32'h0);
        chk("rst_dat_o", bus.wb_dat_o, 32'h0);
        chk("rst_misc",  {27'h0, bus.apb_write, bus.apb_pstb}, 32'h0);
        rst = 1'b0;
        step();

        xfer("write",   1'b1, 32'h3000_0000, 32'h000A_BCDE, 4'hF, 0,  32'h0,         0, 0);
        xfer("read",    1'b0, 32'h3000_0004, 32'h0,         4'hF, 0,  32'h0001_2345, 0, 0);
        xfer("wait3",   1'b0, 32'h3000_0010, 32'h0,         4'h3, 3,  32'hCAFE_0001, 0, 0);
        xfer("wait15",  1'b0, 32'h3000_0020, 32'h0,         4'hF, 15, 32'h1234_5678, 0, 0);
        xfer("timeout", 1'b0, 32'h3000_0024, 32'h0,         4'hF, 16, 32'hDEAD_BEEF, 0, 0);
        xfer("oow_hi",  1'b0, 32'h3001_0000, 32'h0,         4'hF, 0,  32'h0,         0, 0);
        xfer("oow_lo",  1'b1, 32'h2000_0000, 32'h5,         4'hF, 0,  32'h0,         0, 0);
        xfer("abort",   1'b1, 32'h3000_0030, 32'h0000_0777, 4'h1, 2,  32'h0,         1, 0);

        // Reset while the transfer sits in ACCESS.
        bus.wb_cyc = 1'b1;
        bus.wb_stb = 1'b1;
        bus.wb_we  = 1'b0;
        bus.wb_adr = 32'h3000_0008;
        bus.apb_rready = 1'b0;
        step();
        step();
        chk("rst_mid_access", vec(), 32'hC);
        rst = 1'b1;
        step();
        chk("rst_mid_phase", vec(), 32'h0);
        chk("rst_mid_addr",  bus.apb_addr, 32'h0);
        rst = 1'b0;
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        step();
        chk("rst_mid_idle", vec(), 32'h0);

        xfer("b2b_first",  1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h0000_00AA, 0, 1);
        xfer("b2b_second", 1'b0, 32'h3000_000C, 32'h0, 4'hF, 1, 32'h0000_00BB, 0, 0);

        for (int i = 0; i < 24; i++) begin
            a = {16'h3000, 16'($urandom)};
            d = $urandom;
            r = $urandom;
            w = (i % 6 == 5) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            xfer("rand", 1'($urandom), a, d, 4'($urandom), w, r, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
